// File: rtl/ucode_ram_arbiter.sv
// rtl/ucode_ram_arbiter.sv - fetch/loader arbiter for the single-port microinstruction RAM
module ucode_ram_arbiter #(
    parameter int RAM_WIDTH  = 22,
    parameter int ADDR_SIZE  = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 f_req,
    input  logic [ADDR_SIZE-1:0] f_addr,
    output logic                 f_gnt,
    output logic                 f_rvalid,
    output logic [RAM_WIDTH-1:0] f_rdata,
    input  logic                 l_req,
    input  logic                 l_we,
    input  logic [ADDR_SIZE-1:0] l_addr,
    input  logic [RAM_WIDTH-1:0] l_wdata,
    output logic                 l_gnt,
    output logic                 l_rvalid,
    output logic [RAM_WIDTH-1:0] l_rdata,
    output logic                 ram_wr_enb,
    output logic                 ram_rd_enb,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    owner_e          rd_owner_q, rd_owner_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            starve_full;

    assign starve_full = (starve_cnt_q == CW'(STARVE_MAX));

    // Fetch wins ties unless the loader has been denied STARVE_MAX cycles in a row.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset_n) begin
            if (f_req && !(l_req && starve_full)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_wr_enb  = 1'b0;
        ram_rd_enb  = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        rd_owner_d  = OWN_NONE;
        if (f_gnt) begin
            ram_rd_enb = 1'b1;
            ram_addr   = f_addr;
            rd_owner_d = OWN_FETCH;
        end else if (l_gnt) begin
            ram_addr = l_addr;
            if (l_we) begin
                ram_wr_enb  = 1'b1;
                ram_data_in = l_wdata;
            end else begin
                ram_rd_enb = 1'b1;
                rd_owner_d = OWN_LOAD;
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (l_req && !l_gnt) begin
            starve_cnt_d = starve_full ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_owner_q   <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign f_rvalid = (rd_owner_q == OWN_FETCH);
    assign l_rvalid = (rd_owner_q == OWN_LOAD);
    assign f_rdata  = ram_data_out;
    assign l_rdata  = ram_data_out;

endmodule

// File: doc/ucode_ram_arbiter.md
Name: ucode_ram_arbiter

Overview:
- Shares the single-port microinstruction RAM between two requesters.
  - Fetch port: the microsequencer, read-only.
  - Loader port: host/debug program loader, read or write.
- Sits between the two requesters and the RAM (22-bit words, 1024 deep, 11-bit address, synchronous read/write, 1-cycle read latency, data_out holds when rd_enb is low).
- Fetch has priority; a starvation counter guarantees loader progress.

Parameters:
- RAM_WIDTH, 22, microinstruction word width
- ADDR_SIZE, 11, RAM address width
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced a grant (range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_SIZE  fetch address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  RAM_WIDTH  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_SIZE  loader address
- l_wdata  in  RAM_WIDTH  loader write data
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader read data valid
- l_rdata  out  RAM_WIDTH  loader read data
- ram_wr_enb  out  1  to RAM wr_enb
- ram_rd_enb  out  1  to RAM rd_enb
- ram_addr  out  ADDR_SIZE  to RAM addr
- ram_data_in  out  RAM_WIDTH  to RAM data_in
- ram_data_out  in  RAM_WIDTH  from RAM data_out

Behaviour:
- Reset (reset_n=0, asynchronous):
  - f_rvalid=0, l_rvalid=0, starve_cnt=0, rd_owner=NONE.
  - While reset_n=0: f_gnt, l_gnt, ram_wr_enb, ram_rd_enb forced to 0.
  - ram_addr, ram_data_in = 0 whenever nothing is granted.
- Handshake:
  - A request is accepted in the cycle req=1 and gnt=1; the RAM samples at that rising edge.
  - Requesters hold req, addr, we and wdata stable until granted.
  - One access per cycle; back-to-back grants are allowed.
- Grant rule (combinational from req and starve_cnt):
  - Only f_req → fetch.
  - Only l_req → loader.
  - Both, starve_cnt < STARVE_MAX → fetch.
  - Both, starve_cnt == STARVE_MAX → loader.
- starve_cnt update (registered):
  - l_req & ~l_gnt → +1, saturating at STARVE_MAX.
  - Otherwise → 0.
- RAM drive:
  - Fetch granted: ram_rd_enb=1, ram_wr_enb=0, ram_addr=f_addr.
  - Loader granted, l_we=1: ram_wr_enb=1, ram_rd_enb=0, ram_addr=l_addr, ram_data_in=l_wdata.
  - Loader granted, l_we=0: ram_rd_enb=1, ram_addr=l_addr.
- Read return:
  - rd_owner is registered on each granted read; NONE on a write or idle cycle.
  - In the cycle after the grant, rvalid=1 for exactly one cycle on the owner port only.
  - rdata on both ports is ram_data_out, passed through combinationally.
  - Data is meaningful only while that port's rvalid=1.
- Loader write gives no rvalid; it is complete at the grant edge.
- Read and write to the same address in consecutive cycles: the read returns the new data (RAM write happens at the earlier edge).
- Reset mid-operation: any pending rvalid is dropped and the request must be re-issued; starvation history is lost.
- Address wrap: none; addresses ≥ RAM_DEPTH are passed through unchanged (the RAM ignores them).

Test Plan:
1. Reset: hold reset_n=0 with f_req=1 and l_req=1 → all gnt, enb and rvalid = 0. Release → f_gnt=1 on the first edge.
2. Fetch only: f_req=1, f_addr=0..3 on consecutive cycles, RAM preloaded → f_rvalid high on cycles 1..4, f_rdata equals mem[0..3] in order, l_rvalid=0 throughout.
3. Loader write then read: l_we=1, l_addr=200, l_wdata=22'h0A5A5A; next cycle l_we=0, l_addr=200 → l_rvalid one cycle after the read grant, l_rdata=22'h0A5A5A, no f_rvalid.
4. Starvation: f_req and l_req held high continuously, STARVE_MAX=4 → f_gnt for 4 cycles, l_gnt on the 5th, starve_cnt returns to 0, f_gnt again from the 6th; repeating period of 5.
5. Simultaneous with loader alone: l_req=1, f_req=0 → l_gnt the same cycle, starve_cnt stays 0.
6. Reset mid-read: fetch granted, reset_n pulsed low before the next edge → f_rvalid stays 0; after release, the re-issued request behaves as in scenario 2.
